// File: rtl/secded_decoder_pipe.sv
// secded_decoder_pipe: two-stage Hsiao SECDED decoder with valid/ready
// stream ports, saturating error counters and a sticky first-error log.
//
// Ports:
//   CLK, RST             clock, synchronous active-high reset
//   IN_VALID/IN_READY    input handshake, E_DATA codeword, CORR_EN mode
//   OUT_VALID/OUT_READY  output handshake
//   D_DATA, SYND         (corrected) data and syndrome of output word
//   ERR, S_ERR, D_ERR    any / correctable / uncorrectable error
//   CNT_CLR, SE_CNT, DE_CNT   counter clear and saturating counts
//   LOG_CLR, LOG_VALID, LOG_SYND, LOG_UNCORR   first-error log
module secded_decoder_pipe #(
  parameter int DATA_W = 64,
  parameter int CHK_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    IN_VALID,
  output logic                    IN_READY,
  input  logic [DATA_W+CHK_W-1:0] E_DATA,
  input  logic                    CORR_EN,
  output logic                    OUT_VALID,
  input  logic                    OUT_READY,
  output logic [DATA_W-1:0]       D_DATA,
  output logic [CHK_W-1:0]        SYND,
  output logic                    ERR,
  output logic                    S_ERR,
  output logic                    D_ERR,
  input  logic                    CNT_CLR,
  output logic [CNT_W-1:0]        SE_CNT,
  output logic [CNT_W-1:0]        DE_CNT,
  input  logic                    LOG_CLR,
  output logic                    LOG_VALID,
  output logic [CHK_W-1:0]        LOG_SYND,
  output logic                    LOG_UNCORR
);

  localparam int CW_W = DATA_W + CHK_W;

  function automatic bit col_ok(input logic [CHK_W-1:0] c);
    return ($countones(c) >= 3) && ($countones(c) % 2 == 1);
  endfunction

  function automatic int n_cols();
    int n;
    n = 0;
    for (int v = 0; v < (1 << CHK_W); v++)
      if (col_ok(CHK_W'(v))) n++;
    return n;
  endfunction

  // i-th odd-weight (>=3) value in ascending order
  function automatic logic [CHK_W-1:0] h_col(input int idx);
    int                 k;
    logic [CHK_W-1:0]   res;
    k   = 0;
    res = '0;
    for (int v = 0; v < (1 << CHK_W); v++) begin
      if (col_ok(CHK_W'(v))) begin
        if (k == idx) res = CHK_W'(v);
        k++;
      end
    end
    return res;
  endfunction

  if (DATA_W < 8 || DATA_W > 64 || n_cols() < DATA_W) begin : g_param_chk
    $error("secded_decoder_pipe: illegal DATA_W/CHK_W combination");
  end

  logic [CHK_W-1:0] w_col [DATA_W];

  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_col
    localparam logic [CHK_W-1:0] C = h_col(gi);
    assign w_col[gi] = C;
  end

  logic              r_s1_v;
  logic [CW_W-1:0]   r_s1_cw;
  logic              r_s1_ce;
  logic              r_s2_v;
  logic [DATA_W-1:0] r_data;
  logic [CHK_W-1:0]  r_synd;
  logic              r_serr;
  logic              r_derr;
  logic [CNT_W-1:0]  r_se_cnt;
  logic [CNT_W-1:0]  r_de_cnt;
  logic              r_log_v;
  logic [CHK_W-1:0]  r_log_synd;
  logic              r_log_unc;

  logic              w_s2_en;
  logic              w_load;
  logic [CHK_W-1:0]  w_synd;
  logic [DATA_W-1:0] w_flip;
  logic              w_chit;
  logic              w_serr;
  logic              w_derr;
  logic [DATA_W-1:0] w_data;

  assign w_s2_en  = !r_s2_v || OUT_READY;
  assign w_load   = w_s2_en && r_s1_v;
  assign IN_READY = !(r_s1_v && r_s2_v && !OUT_READY);

  always_comb begin
    w_synd = r_s1_cw[CW_W-1:DATA_W];
    for (int i = 0; i < DATA_W; i++)
      if (r_s1_cw[i]) w_synd = w_synd ^ w_col[i];
    w_flip = '0;
    for (int i = 0; i < DATA_W; i++)
      if (w_synd == w_col[i]) w_flip[i] = 1'b1;
    // every column has odd weight, so a match implies odd weight
    w_chit = $onehot(w_synd);
    w_serr = (|w_flip) || w_chit;
    w_derr = (|w_synd) && !w_serr;
    w_data = r_s1_cw[DATA_W-1:0];
    if (r_s1_ce) w_data = w_data ^ w_flip;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_s1_v     <= 1'b0;
      r_s1_cw    <= '0;
      r_s1_ce    <= 1'b0;
      r_s2_v     <= 1'b0;
      r_data     <= '0;
      r_synd     <= '0;
      r_serr     <= 1'b0;
      r_derr     <= 1'b0;
      r_se_cnt   <= '0;
      r_de_cnt   <= '0;
      r_log_v    <= 1'b0;
      r_log_synd <= '0;
      r_log_unc  <= 1'b0;
    end else begin
      if (IN_READY) begin
        r_s1_v <= IN_VALID;
        if (IN_VALID) begin
          r_s1_cw <= E_DATA;
          r_s1_ce <= CORR_EN;
        end
      end
      if (w_s2_en) begin
        r_s2_v <= r_s1_v;
        if (r_s1_v) begin
          r_data <= w_data;
          r_synd <= w_synd;
          r_serr <= w_serr;
          r_derr <= w_derr;
        end
      end
      if (CNT_CLR) begin
        r_se_cnt <= '0;
        r_de_cnt <= '0;
      end else begin
        if (w_load && w_serr && !(&r_se_cnt))
          r_se_cnt <= r_se_cnt + CNT_W'(1);
        if (w_load && w_derr && !(&r_de_cnt))
          r_de_cnt <= r_de_cnt + CNT_W'(1);
      end
      // a clear in the same cycle as a new error still captures it
      if (w_load && (w_serr || w_derr) && (!r_log_v || LOG_CLR)) begin
        r_log_v    <= 1'b1;
        r_log_synd <= w_synd;
        r_log_unc  <= w_derr;
      end else if (LOG_CLR) begin
        r_log_v <= 1'b0;
      end
    end
  end

  assign OUT_VALID  = r_s2_v;
  assign D_DATA     = r_data;
  assign SYND       = r_synd;
  assign S_ERR      = r_serr;
  assign D_ERR      = r_derr;
  assign ERR        = r_serr || r_derr;
  assign SE_CNT     = r_se_cnt;
  assign DE_CNT     = r_de_cnt;
  assign LOG_VALID  = r_log_v;
  assign LOG_SYND   = r_log_synd;
  assign LOG_UNCORR = r_log_unc;

endmodule

// File: tb/tb_secded_decoder_pipe.sv
// tb_secded_decoder_pipe: random and directed stimulus for
// secded_decoder_pipe, checked against a queue-based reference model.
module tb_secded_decoder_pipe;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, iv, ce, ord, cclr, lclr;
  logic [71:0] cw;

  logic        ir, ov, er, sf, df, lv_o, lun_o;
  logic [63:0] dd;
  logic [7:0]  sy, lsy_o;
  logic [15:0] sec, dec;

  logic        ir2, ov2, er2, sf2, df2, lv2, lun2;
  logic [63:0] dd2;
  logic [7:0]  sy2, lsy2;
  logic [3:0]  sec2, dec2;

  secded_decoder_pipe u_dut (
    .CLK(clk), .RST(rst), .IN_VALID(iv), .IN_READY(ir),
    .E_DATA(cw), .CORR_EN(ce), .OUT_VALID(ov), .OUT_READY(ord),
    .D_DATA(dd), .SYND(sy), .ERR(er), .S_ERR(sf), .D_ERR(df),
    .CNT_CLR(cclr), .SE_CNT(sec), .DE_CNT(dec), .LOG_CLR(lclr),
    .LOG_VALID(lv_o), .LOG_SYND(lsy_o), .LOG_UNCORR(lun_o)
  );

  secded_decoder_pipe #(.DATA_W(64), .CHK_W(8), .CNT_W(4)) u_sat (
    .CLK(clk), .RST(rst), .IN_VALID(iv), .IN_READY(ir2),
    .E_DATA(cw), .CORR_EN(ce), .OUT_VALID(ov2), .OUT_READY(ord),
    .D_DATA(dd2), .SYND(sy2), .ERR(er2), .S_ERR(sf2), .D_ERR(df2),
    .CNT_CLR(cclr), .SE_CNT(sec2), .DE_CNT(dec2), .LOG_CLR(lclr),
    .LOG_VALID(lv2), .LOG_SYND(lsy2), .LOG_UNCORR(lun2)
  );

  typedef struct {
    logic [63:0] data;
    logic [7:0]  synd;
    bit          err;
    bit          s;
    bit          d;
    int          acc;
    bit          shown;
  } exp_t;

  int          checks = 0;
  int          failures = 0;
  exp_t        q[$];
  logic [7:0]  hcol [72];
  int          k_cyc = 0;
  int          mode = 0;
  bit [3:0]    pat = 4'b1001;

  int          m_se, m_de, m_se4, m_de4;
  bit          m_lv, m_lun, was_rst;
  logic [7:0]  m_lsy;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic exp_t ref_dec(input logic [71:0] w, input bit c);
    exp_t       r;
    logic [7:0] s;
    int         hit;
    s   = 8'h00;
    hit = -1;
    for (int b = 0; b < 72; b++) if (w[b]) s = s ^ hcol[b];
    for (int b = 0; b < 72; b++) if (s != 0 && hcol[b] == s) hit = b;
    r.data  = w[63:0];
    r.synd  = s;
    r.s     = (hit >= 0);
    r.d     = (s != 0) && (hit < 0);
    r.err   = (s != 0);
    if (c && hit >= 0 && hit < 64) r.data[hit] = ~r.data[hit];
    r.acc   = 0;
    r.shown = 0;
    return r;
  endfunction

  function automatic logic [71:0] encode(input logic [63:0] d);
    logic [7:0] s;
    s = 8'h00;
    for (int b = 0; b < 64; b++) if (d[b]) s = s ^ hcol[b];
    return {s, d};
  endfunction

  // reference model and per-cycle compare
  initial begin : model
    int          cyc;
    int          k;
    bit          eov, loaded;
    exp_t        e, ld;
    logic [71:0] t;
    cyc = 0;
    k = 0;
    for (int v = 1; v < 256 && k < 64; v++) begin
      if ($countones(v) >= 3 && ($countones(v) % 2) == 1) begin
        hcol[k] = v[7:0];
        k++;
      end
    end
    for (int j = 0; j < 8; j++) hcol[64+j] = 8'(1 << j);
    chk("pin_col0", hcol[0], 8'h07);
    chk("pin_col1", hcol[1], 8'h0B);
    e = ref_dec(72'h1, 1'b1);
    chk("pin_b0_synd", e.synd, 8'h07);
    chk("pin_b0_s", e.s, 1);
    chk("pin_b0_data", e.data, 0);
    e = ref_dec(72'h1, 1'b0);
    chk("pin_b0_nocorr", e.data, 1);
    e = ref_dec(72'h3, 1'b1);
    chk("pin_dbl_synd", e.synd, 8'h0C);
    chk("pin_dbl_d", e.d, 1);
    chk("pin_dbl_data", e.data, 3);
    t = '0;
    t[71:65] = '1;
    e = ref_dec(t, 1'b1);
    chk("pin_chk_synd", e.synd, 8'hFE);
    chk("pin_chk_d", e.d, 1);
    e = ref_dec(encode(64'h0123_4567_89AB_CDEF), 1'b1);
    chk("pin_clean", e.err, 0);
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        q.delete();
        m_se = 0; m_de = 0; m_se4 = 0; m_de4 = 0;
        m_lv = 0; m_lsy = 0; m_lun = 0;
        was_rst = 1;
      end else begin
        was_rst = 0;
        eov = q.size() > 0 && q[0].shown;
        if (eov && ord) void'(q.pop_front());
        if (iv && !(q.size() == 2 && !ord && eov)) begin
          e = ref_dec(cw, ce);
          e.acc = cyc;
          q.push_back(e);
        end
        loaded = 0;
        if (q.size() > 0 && !q[0].shown && q[0].acc <= cyc - 1) begin
          q[0].shown = 1;
          loaded = 1;
          ld = q[0];
        end
        if (cclr) begin
          m_se = 0; m_de = 0; m_se4 = 0; m_de4 = 0;
        end else if (loaded) begin
          if (ld.s) begin
            if (m_se < 65535) m_se++;
            if (m_se4 < 15) m_se4++;
          end
          if (ld.d) begin
            if (m_de < 65535) m_de++;
            if (m_de4 < 15) m_de4++;
          end
        end
        if (loaded && ld.err && (!m_lv || lclr)) begin
          m_lv = 1; m_lsy = ld.synd; m_lun = ld.d;
        end else if (lclr) begin
          m_lv = 0;
        end
      end
      #1;
      eov = q.size() > 0 && q[0].shown;
      chk("out_valid", ov, eov);
      chk("out_valid_w4", ov2, eov);
      chk("in_ready", ir, !(q.size() == 2 && !ord));
      if (eov) begin
        chk("d_data", dd, q[0].data);
        chk("synd", sy, q[0].synd);
        chk("err", er, q[0].err);
        chk("s_err", sf, q[0].s);
        chk("d_err", df, q[0].d);
        chk("d_data_w4", dd2, q[0].data);
      end
      if (was_rst) begin
        chk("rst_d_data", dd, 0);
        chk("rst_synd", sy, 0);
        chk("rst_flags", {er, sf, df}, 0);
        chk("rst_log", {lsy_o, lun_o}, 0);
      end
      chk("se_cnt", sec, m_se);
      chk("de_cnt", dec, m_de);
      chk("se_cnt_w4", sec2, m_se4);
      chk("de_cnt_w4", dec2, m_de4);
      chk("log_valid", lv_o, m_lv);
      if (m_lv) begin
        chk("log_synd", lsy_o, m_lsy);
        chk("log_uncorr", lun_o, m_lun);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    k_cyc++;
    case (mode)
      1:       ord = pat[k_cyc % 4];
      2:       ord = ($urandom_range(0, 3) != 0);
      default: ord = 1'b1;
    endcase
  endtask

  task automatic send(input logic [71:0] w);
    bit a;
    a  = 0;
    iv = 1'b1;
    cw = w;
    for (int t = 0; t < 64 && !a; t++) begin
      #1;
      a = ir;
      tick();
    end
    checks++;
    if (!a) begin
      failures++;
      $display("FAIL accept_timeout actual=0 required=1");
    end
  endtask

  function automatic logic [71:0] gen();
    logic [71:0] w;
    int          a, b;
    w = encode({$urandom, $urandom});
    case ($urandom_range(0, 3))
      1: begin
        a = $urandom_range(0, 71);
        w[a] = ~w[a];
      end
      2: begin
        a = $urandom_range(0, 71);
        b = (a + 1 + $urandom_range(0, 70)) % 72;
        w[a] = ~w[a];
        w[b] = ~w[b];
      end
      3: w = {8'($urandom), $urandom, $urandom};
      default: ;
    endcase
    return w;
  endfunction

  initial begin : driver
    logic [71:0] w;
    rst = 1'b1; iv = 1'b0; cw = '0; ce = 1'b1;
    ord = 1'b1; cclr = 1'b0; lclr = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) send(72'h0);
    send(72'h1);
    ce = 1'b0;
    send(72'h1);
    ce = 1'b1;
    send(72'h3);
    w = '0;
    w[71:65] = '1;
    send(w);
    send(72'h3);
    iv = 1'b0;
    repeat (4) tick();
    chk("lit_se_cnt", sec, 2);
    chk("lit_de_cnt", dec, 3);
    chk("lit_log_synd", {lv_o, lsy_o, lun_o}, {1'b1, 8'h07, 1'b0});

    mode = 1;
    for (int i = 0; i < 5; i++)
      send(encode(64'hA5A5_0000_0000_0000 + 64'(i * 4099)));
    iv = 1'b0;
    repeat (8) tick();
    mode = 0;
    tick();

    for (int i = 0; i < 20; i++) begin
      w = encode({$urandom, $urandom});
      w[(i * 7) % 72] = ~w[(i * 7) % 72];
      send(w);
    end
    iv = 1'b0;
    repeat (4) tick();
    chk("lit_se_sat", sec2, 15);

    send(72'h1);
    cclr = 1'b1;
    send(72'h2);
    cclr = 1'b0;
    chk("lit_cnt_clr", {sec, sec2}, 0);
    iv = 1'b0;
    repeat (3) tick();

    send(72'h3);
    lclr = 1'b1;
    send(72'h5);
    lclr = 1'b0;
    chk("lit_log_clr", {lv_o, lsy_o, lun_o}, {1'b1, 8'h0C, 1'b1});
    iv = 1'b0;
    repeat (3) tick();
    chk("lit_log_keep", lsy_o, 8'h0C);

    mode = 2;
    for (int n = 0; n < 1500; n++) begin
      rst  = (n == 900);
      iv   = ($urandom_range(0, 3) != 0);
      ce   = ($urandom_range(0, 3) != 0);
      cclr = ($urandom_range(0, 49) == 0);
      lclr = ($urandom_range(0, 19) == 0);
      cw   = gen();
      tick();
    end
    rst = 1'b0; iv = 1'b0; cclr = 1'b0; lclr = 1'b0;
    mode = 0;
    repeat (6) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/secded_decoder_pipe.md
Name: secded_decoder_pipe

Overview:
- Parametrised, pipelined SECDED (Hsiao-style) decoder with a valid/ready stream interface.
- Accepts a DATA_W+CHK_W codeword, computes the syndrome and corrects single-bit errors.
- Flags uncorrectable errors and keeps saturating error counters plus a sticky first-error log.
- Sits between memory read-return and consumer logic in the ECC-protected datapath.

Parameters:
DATA_W, 64, data bits per codeword; legal 8..64.
CHK_W, 8, check bits; must satisfy (number of CHK_W-bit odd-weight values of weight >=3) >= DATA_W; elaboration error otherwise.
CNT_W, 16, width of each error counter.

Ports:
CLK  in  1  clock
RST  in  1  synchronous, active-high reset
IN_VALID  in  1  input codeword valid
IN_READY  out  1  decoder can accept a codeword this cycle
E_DATA  in  DATA_W+CHK_W  codeword; data in [DATA_W-1:0], check bit j at [DATA_W+j]
CORR_EN  in  1  1 = correct single-bit errors; 0 = detect only, data passed uncorrected
OUT_VALID  out  1  result valid
OUT_READY  in  1  consumer accepts result
D_DATA  out  DATA_W  (corrected) data
SYND  out  CHK_W  syndrome of the output word
ERR  out  1  syndrome nonzero
S_ERR  out  1  correctable (single-bit) error
D_ERR  out  1  uncorrectable error
CNT_CLR  in  1  synchronous clear of both counters
SE_CNT  out  CNT_W  correctable-error count, saturating
DE_CNT  out  CNT_W  uncorrectable-error count, saturating
LOG_CLR  in  1  clear the error log
LOG_VALID  out  1  log holds a captured error
LOG_SYND  out  CHK_W  syndrome of the first logged error
LOG_UNCORR  out  1  logged error was uncorrectable

Behaviour:
- Clock is CLK. Reset is RST: one clock, synchronous, active-high.
- H-matrix, data column i: the i-th (from 0) CHK_W-bit value, in ascending numeric order, with odd weight >=3. Check-bit column j: one-hot bit j. Compute via a constant function.
- Syndrome bit j = XOR of all codeword bits whose column has bit j set.
- Classification:
  - syndrome 0: no error.
  - odd weight, matches a data or check column: S_ERR=1. If CORR_EN=1, flip that bit; a check-bit match leaves data unchanged.
  - even nonzero: D_ERR=1.
  - odd weight, no column match: D_ERR=1.
  - ERR = S_ERR | D_ERR. S_ERR and D_ERR are never both 1.
  - D_DATA is uncorrected whenever D_ERR=1 or CORR_EN=0.
- Pipeline, two register stages:
  - S1 registers the codeword and the CORR_EN sampled on acceptance.
  - S2 registers D_DATA, SYND and the flags. Outputs come directly from S2.
  - Latency: accepted at edge N -> OUT_VALID at edge N+2 with no backpressure. Throughput 1 word/cycle.
- Handshake:
  - Transfer occurs when VALID & READY on a rising edge.
  - S2 loads when S2 is empty or OUT_READY=1. S1 loads when S1 is empty or S1 moves to S2.
  - IN_READY = !(S1 full & S2 full & !OUT_READY), combinational.
  - Output holds stable while OUT_VALID & !OUT_READY. No bubbles under continuous flow; no word is dropped or duplicated.
- Counters:
  - Increment once per word when it loads into S2, by S_ERR or D_ERR. Saturate at all-ones.
  - CNT_CLR and an increment in the same cycle -> counter = 0; that event is lost.
- Log:
  - When LOG_VALID=0 and a word with ERR=1 loads into S2, capture its SYND and D_ERR and set LOG_VALID. Later errors are ignored.
  - LOG_CLR clears LOG_VALID. LOG_CLR plus a new error in the same cycle -> the new error is captured.
- Reset:
  - S1/S2 valid=0; OUT_VALID=0.
  - D_DATA, SYND, ERR, S_ERR, D_ERR = 0.
  - Counters = 0; LOG_VALID, LOG_SYND, LOG_UNCORR = 0.
  - IN_READY=1 in the cycle after reset deasserts.
  - Reset mid-stream discards in-flight words and leaves counters unchanged by them.

Test Plan:
- Defaults, E_DATA=0, IN_VALID held 1, OUT_READY=1 -> OUT_VALID at edge N+2; D_DATA=0, SYND=0x00, ERR=0.
- Data bit 0 flipped (E_DATA=1), CORR_EN=1 -> SYND=0x07, S_ERR=1, D_DATA=0, SE_CNT=1, LOG_VALID=1, LOG_SYND=0x07. Repeat with CORR_EN=0 -> D_DATA=1, S_ERR=1.
- Data bits 0 and 1 flipped -> SYND=0x0C, D_ERR=1, D_DATA=0x3. Check bits 65..71 flipped -> SYND=0xFE, D_ERR=1 (odd, unmatched). DE_CNT increments once per word.
- Backpressure: 5 distinct words with OUT_READY pattern 1,0,0,1,1,... -> IN_READY drops when both stages are full; the 5 outputs appear in order, each held while OUT_READY=0.
- CNT_W=4, 20 single-bit-error words -> SE_CNT saturates at 15. CNT_CLR coincident with an error word -> SE_CNT=0.
- LOG_CLR coincident with a D_ERR word -> LOG_VALID=1 with the new syndrome and LOG_UNCORR=1. RST asserted mid-stream -> all outputs 0 on the next cycle.
